alu_exec_pipe: RTL

Two-stage registered execution pipeline for the 64-bit signed ALU. It accepts an operand pair and an opcode over a valid/ready handshake and latches them in stage 1. It evaluates the selected operation (add, sub, and, or, xor, not, set-less-than) in stage 2 and presents a registered result with status flags over a second valid/ready handshake. It sits directly upstream of result writeback and wraps the ALU's combinational bitwise units (including the 64-bit XOR) so that they see stable, registered operands.

---
 rtl/alu_exec_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_exec_pipe.sv
// Two-stage registered ALU execution pipeline with valid/ready on both sides.
// S1 latches operands and opcode; S2 holds the evaluated result, flags and the consumed-result counter.
module alu_exec_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SLT = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    op_e                     s1_op;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_y;
    logic             res_ovf;
    logic             res_err;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else begin
            if (accept) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op_e'(op);
            end
            // An accept refills S1 even when its previous occupant advances this cycle.
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
        end
    end

    always_comb begin
        sum     = s1_a + s1_b;
        diff    = s1_a - s1_b;
        res_y   = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res_y   = sum;
                res_ovf = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res_y   = diff;
                res_ovf = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OP_AND: res_y = s1_a & s1_b;
            OP_OR:  res_y = s1_a | s1_b;
            OP_XOR: res_y = s1_a ^ s1_b;
            OP_NOT: res_y = ~s1_a;
            OP_SLT: res_y = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            default: begin
                res_y   = '0;
                res_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            op_count  <= '0;
        end else begin
            if (s1_adv) begin
                y    <= res_y;
                zero <= (res_y == '0);
                ovf  <= res_ovf;
                err  <= res_err;
            end
            if (s1_adv)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (out_valid && out_ready)
                op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
